// File: rtl/half_band_pkg.sv
`default_nettype none
// ============================================================================
// Module      : half_band_pkg
// Description : Shared widths, coefficients and state encoding for the
//               half-band interpolator and decimator stages.
// Revision    : 1.0 - initial release
// ============================================================================
package half_band_pkg;

   localparam int HB_W      = 18;   // sample width
   localparam int HB_SUM_W  = 19;   // symmetric tap-pair sum width
   localparam int HB_PROD_W = 37;   // coefficient * tap-pair product width
   localparam int HB_ACC_W  = 38;   // sum of the two products
   localparam int HB_SHIFT  = 17;   // Q0.18 scaling with the x2 interpolation gain folded in

   // Q0.18 signed half-band coefficients shared with the receive-side filter
   localparam logic signed [HB_W-1:0] HB_C0 = -18'sd12940;
   localparam logic signed [HB_W-1:0] HB_C1 = 18'sd77324;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PH_A = 2'd1,
      PH_B = 2'd2
   } hb_state_t;

endpackage
`default_nettype wire

// File: rtl/hb_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : hb_round_sat
// Description : Round-half-up, arithmetic shift by HB_SHIFT and saturate a
//               38-bit accumulator to an 18-bit signed sample.
// Revision    : 1.0 - initial release
// ============================================================================
module hb_round_sat
   import half_band_pkg::*;
(
   input  logic signed [HB_ACC_W-1:0] acc,
   output logic signed [HB_W-1:0]     q
);

   localparam logic signed [HB_ACC_W-1:0] HALF    = HB_ACC_W'(64'sd1 <<< (HB_SHIFT - 1));
   localparam logic signed [HB_ACC_W-1:0] SAT_MAX = HB_ACC_W'(64'sd131071);
   localparam logic signed [HB_ACC_W-1:0] SAT_MIN = HB_ACC_W'(-64'sd131072);

   logic signed [HB_ACC_W-1:0] rounded;
   logic signed [HB_ACC_W-1:0] shifted;

   // Round, rescale and clamp to the representable output range
   always_comb begin
      rounded = acc + HALF;
      shifted = rounded >>> HB_SHIFT;
      if (shifted > SAT_MAX) begin
         q = SAT_MAX[HB_W-1:0];
      end else if (shifted < SAT_MIN) begin
         q = SAT_MIN[HB_W-1:0];
      end else begin
         q = shifted[HB_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/half_band_interp_2.sv
`default_nettype none
// ============================================================================
// Module      : half_band_interp_2
// Description : Half-band interpolate-by-2. Each accepted input yields an
//               even-phase sample (delayed centre tap) followed by an
//               odd-phase sample (4-tap symmetric polyphase sum).
// Revision    : 1.0 - initial release
// ============================================================================
module half_band_interp_2
   import half_band_pkg::*;
#(
   parameter logic signed [HB_W-1:0] C0 = HB_C0,
   parameter logic signed [HB_W-1:0] C1 = HB_C1
) (
   input  logic                   clk,
   input  logic                   reset,      // asynchronous, active low
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [HB_W-1:0] x_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [HB_W-1:0] y
);

   hb_state_t state;
   hb_state_t state_nx;

   // Delay line: d0 newest. The oldest tap (d3 after a shift) is exactly d2
   // before the shift, and it is only ever read at accept time, so it needs
   // no storage of its own.
   logic signed [HB_W-1:0]     d0, d1, d2;
   logic signed [HB_SUM_W-1:0] s_out, s_in;
   logic signed [HB_SUM_W-1:0] s_out_nx, s_in_nx;
   logic signed [HB_PROD_W-1:0] prod_out, prod_in;
   logic signed [HB_ACC_W-1:0]  acc;
   logic signed [HB_W-1:0]      odd_sample;
   logic                        accept;

   assign in_ready  = (state == IDLE) | ((state == PH_B) & out_ready);
   assign out_valid = (state != IDLE);
   assign accept    = in_valid & in_ready;

   // Tap-pair sums on the post-shift line: outer = new d0 + new d3, inner = new d1 + new d2
   assign s_out_nx = HB_SUM_W'(x_in) + HB_SUM_W'(d2);
   assign s_in_nx  = HB_SUM_W'(d0)   + HB_SUM_W'(d1);

   assign prod_out = HB_PROD_W'(C0) * HB_PROD_W'(s_out);
   assign prod_in  = HB_PROD_W'(C1) * HB_PROD_W'(s_in);
   assign acc      = HB_ACC_W'(prod_out) + HB_ACC_W'(prod_in);

   hb_round_sat u_round_sat (
      .acc (acc),
      .q   (odd_sample)
   );

   // Next-state logic: a phase advances only when downstream takes it
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = PH_A;
         PH_A:    if (out_ready) state_nx = PH_B;
         PH_B:    if (out_ready) state_nx = in_valid ? PH_A : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Delay line, tap sums and output register: even phase loads on accept,
   // odd phase loads when the even phase is taken
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d0    <= '0;
         d1    <= '0;
         d2    <= '0;
         s_out <= '0;
         s_in  <= '0;
         y     <= '0;
      end else if (accept) begin
         d0    <= x_in;
         d1    <= d0;
         d2    <= d1;
         s_out <= s_out_nx;
         s_in  <= s_in_nx;
         y     <= d1;
      end else if ((state == PH_A) && out_ready) begin
         y     <= odd_sample;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_half_band_interp_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_band_interp_2
// Description : Self-checking bench for half_band_interp_2 against a
//               history-based behavioural model of the filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_band_interp_2;

   localparam int C0V = -12940;
   localparam int C1V = 77324;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [17:0] x_in = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [17:0] y;

   int checks = 0;
   int errors = 0;

   int expq[$];      // outputs the model says are still owed, in order
   int outlog[$];    // outputs actually transferred
   int h[4];         // input history, h[0] newest
   int prev_y;
   bit prev_stall;
   bit rnd_bp = 1'b0;

   half_band_interp_2 dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Rounded, rescaled, clamped filter output from exact integer arithmetic
   function automatic int rs_model(input longint acc);
      longint v;
      v = (acc + 64'sd65536) >>> 17;
      if (v > 131071)  return 131071;
      if (v < -131072) return -131072;
      return int'(v);
   endfunction

   // Compare process: checks handshake, hold, and every transferred sample
   always @(negedge clk) begin
      if (!reset) begin
         expq.delete();
         h = '{0, 0, 0, 0};
         prev_stall = 1'b0;
      end else begin
         check("out_valid", int'(out_valid), int'(expq.size() != 0));
         check("in_ready", int'(in_ready),
               int'(expq.size() == 0 || (expq.size() == 1 && out_ready)));
         if (prev_stall) check("stall_hold_y", int'(y), prev_y);
         prev_stall = out_valid && !out_ready;
         prev_y     = int'(y);
         if (out_valid && out_ready && expq.size() != 0) begin
            check("y", int'(y), expq.pop_front());
            outlog.push_back(int'(y));
         end
         if (in_valid && in_ready) begin
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = int'(x_in);
            expq.push_back(h[2]);
            expq.push_back(rs_model(longint'(C0V) * longint'(h[0] + h[3]) +
                                    longint'(C1V) * longint'(h[1] + h[2])));
         end
      end
   end

   // Random downstream backpressure
   always @(posedge clk) begin
      if (rnd_bp) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, output int acc_t);
      bit ok;
      ok       = 1'b0;
      acc_t    = 0;
      in_valid = 1'b1;
      x_in     = 18'(x);
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok    = 1'b1;
            acc_t = int'($time / 10);
         end
         @(posedge clk);
         #1;
      end
      check("send_timeout", int'(ok), 1);
      in_valid = 1'b0;
      x_in     = 18'($urandom);
   endtask

   task automatic send1(input int x);
      int t;
      send(x, t);
   endtask

   task automatic drain;
      for (int n = 0; n < 200; n++) begin
         if (expq.size() == 0 && !out_valid) break;
         tick();
      end
      check("drain", expq.size(), 0);
   endtask

   function automatic int logv(input int i);
      return (i < outlog.size()) ? outlog[i] : 999999;
   endfunction

   task automatic run_impulse(input string tag);
      int exp_imp[10];
      exp_imp = '{0, -1617, 0, 9666, 16384, 9666, 0, -1617, 0, 0};
      out_ready = 1'b1;
      outlog.delete();
      send1(16384);
      for (int i = 0; i < 4; i++) send1(0);
      drain();
      check({tag, "_count"}, outlog.size(), 10);
      for (int i = 0; i < 10; i++) check({tag, "_y"}, logv(i), exp_imp[i]);
   endtask

   initial begin
      int t_prev, t_cur;

      // Reset state
      reset = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_y", int'(y), 0);
      reset = 1'b1;
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      tick();

      // Impulse
      run_impulse("impulse");

      // DC
      outlog.delete();
      for (int i = 0; i < 8; i++) send1(65536);
      drain();
      check("dc_count", outlog.size(), 16);
      for (int i = 6; i < 16; i++) check("dc_y", logv(i), (i % 2 == 0) ? 65536 : 64384);

      // Saturation
      outlog.delete();
      send1(-131072); send1(131071); send1(131071); send1(-131072);
      drain();
      check("sat_a", logv(6), 131071);
      check("sat_b", logv(7), 131071);

      // Backpressure in PH_A
      outlog.delete();
      send1(1000);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
         tick();
      end
      out_ready = 1'b1;
      drain();
      check("bp_count", outlog.size(), 2);

      // Back-to-back: one accept every two cycles
      send(int'($urandom_range(0, 262143)) - 131072, t_prev);
      for (int i = 0; i < 7; i++) begin
         send(int'($urandom_range(0, 262143)) - 131072, t_cur);
         check("b2b_spacing", t_cur - t_prev, 2);
         t_prev = t_cur;
      end
      drain();

      // Reset while in PH_B
      send1(16384);
      tick();
      check("pre_rst_out_valid", int'(out_valid), 1);
      reset = 1'b0;
      #1;
      check("async_rst_out_valid", int'(out_valid), 0);
      check("async_rst_y", int'(y), 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      run_impulse("post_reset_impulse");

      // Randomized traffic with gaps and backpressure
      rnd_bp = 1'b1;
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send1(int'($urandom_range(0, 262143)) - 131072);
      end
      rnd_bp = 1'b0;
      tick();
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/half_band_interp_2.md
# half_band_interp_2

Half-band interpolate-by-2 block for the transmit/upconversion path. It is the counterpart of the decimating half-band stage on the receive side. It accepts 18-bit signed samples at up to half the clock rate over a valid/ready handshake, and emits two output samples per input. The even phase is the delayed centre-tap sample. The odd phase is a 4-tap symmetric polyphase sum built from the same two half-band coefficients the receive-side filter uses.

## Interface
- `C0`, default -12940: outer coefficient, Q0.18 signed (value/2^18).
- `C1`, default 77324: inner coefficient, Q0.18 signed.
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `in_valid`  in  1  `x_in` holds a sample.
- `in_ready`  out  1  block accepts a sample this cycle; the sample is accepted when `in_valid & in_ready`.
- `x_in`  in  18  signed input sample.
- `out_valid`  out  1  `y` holds an output sample.
- `out_ready`  in  1  downstream takes `y`; the sample is transferred when `out_valid & out_ready`.
- `y`  out  18  signed output sample, registered.

## Operation
- **Delay line:** `d0..d3`, 18 bits each; `d0` holds the newest sample. Each accept shifts the line (`d0<=x_in`, `d(k)<=d(k-1)`).
- **FSM states:**
  - IDLE: `out_valid=0`.
  - PH_A: `y` = even sample, `out_valid=1`.
  - PH_B: `y` = odd sample, `out_valid=1`.
- **`in_ready`** = (state==IDLE) | (state==PH_B & `out_ready`). This is combinational from `out_ready`.
- **Accept:**
  - `y <=` the post-shift `d2` (that is, the pre-shift `d1`).
  - `s_out <=` post-shift `d0+d3` and `s_in <=` post-shift `d1+d2`, each 19-bit signed.
  - Next state is PH_A.
- **PH_A & `out_ready`:** `y <=` rs(`C0*s_out + C1*s_in`); next state is PH_B.
- **PH_B & `out_ready`:** with `in_valid`, accept (go to PH_A); otherwise go to IDLE.
- **Any state with `out_valid & !out_ready`:** hold `y`, state and delay line unchanged.
- **rs() arithmetic:**
  - Products are 37-bit; their sum is 38-bit.
  - Add 2^16, then arithmetic shift right by 17. The factor-2 interpolation gain is folded into this shift.
  - Saturate to [-131072, 131071].
- **Sequence meaning:** output order is x[n-2], then the interpolated x[n-1.5], then x[n-1], and so on.
- **Priming:** the delay line starts at zero and the first three inputs produce start-up transients. These are not suppressed.

## Timing
- **Reset:**
  - `y=0`, `out_valid=0`, state IDLE.
  - Delay line and `s_out`/`s_in` all zero.
  - `in_ready` reads 1 once reset deasserts.
- **Latency:** an accept at edge k gives `out_valid=1` with phase A after edge k. Phase B appears on the edge after phase A is taken.
- **Throughput:** with `out_ready` held at 1, one input every 2 cycles and one output every cycle, with no bubbles.
- **Reset mid-operation:** any pending PH_A or PH_B sample is dropped. There is no output on the first cycle after release.
- **Simultaneous events:** in PH_B with `out_ready & in_valid`, the phase-B transfer and the next accept occur on the same edge.
- **`x_in` sampling:** `x_in` is sampled only when an accept occurs. Its value is ignored at all other times.

## Structure
- **Package `half_band_pkg`:**
  - `HB_W=18`; `HB_C0`, `HB_C1` constants. The receive-side filter is to be switched over to these as well.
  - State enum {IDLE, PH_A, PH_B}.
  - Widths: sum 19, accumulator 38.
- **Sub-module `hb_round_sat`:** 38-bit signed in, with round, shift-17 and saturate, giving 18-bit out. It is combinational and reusable by the decimator.
- **Top:** FSM, delay line, sum registers and output register.

## Test plan
- **Impulse:** with `out_ready=1`, feed 16384, 0, 0, 0, 0.
  - Required `y`: 0, -1617, 0, 9666, 16384, 9666, 0, -1617, 0, 0.
- **DC:** feed constant 65536 for 8 samples.
  - After priming, `y` alternates 65536 / 64384.
- **Saturation:** feed -131072, 131071, 131071, -131072.
  - Fourth pair: A=131071, B=131071 (saturated; the unclamped value is 180527).
- **Backpressure:** hold `out_ready=0` for 5 cycles while in PH_A.
  - `y` stays stable and `in_ready=0`.
  - After release, A is taken then B, with no sample lost or duplicated.
- **Back-to-back:** hold `in_valid=1` and `out_ready=1` continuously.
  - `in_ready` toggles 1,0,1,0.
  - `out_valid` stays 1 every cycle after the first.
- **Reset:** pull `reset` low in PH_B.
  - `out_valid=0` and `y=0` immediately (asynchronously).
  - Next impulse response matches the impulse test from a clean delay line.
